// File: rtl/param_reg_file_sb_if.sv
// Bus bundle for param_reg_file_sb: read ports, writeback, reservation and scoreboard status.
interface param_reg_file_sb_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 32,
   parameter int NREAD = 3
);
   localparam int AW = $clog2(DEPTH);

   logic [NREAD*AW-1:0]   ra;
   logic [NREAD*XLEN-1:0] rd;
   logic [NREAD-1:0]      rbusy;
   logic                  we;
   logic [AW-1:0]         wa;
   logic [XLEN-1:0]       wd;
   logic                  rsv_en;
   logic [AW-1:0]         rsv_addr;
   logic                  rsv_grant;
   logic                  flush;
   logic [AW:0]           busy_cnt;

   modport master (
      output ra, we, wa, wd, rsv_en, rsv_addr, flush,
      input  rd, rbusy, rsv_grant, busy_cnt
   );

   modport slave (
      input  ra, we, wa, wd, rsv_en, rsv_addr, flush,
      output rd, rbusy, rsv_grant, busy_cnt
   );
endinterface

// File: rtl/param_reg_file_sb.sv
// Parametrised NREAD-read / 1-write register file with optional zero register,
// write-to-read bypass and a pending-write scoreboard for multi-cycle ops.
module param_reg_file_sb #(
   parameter int XLEN     = 32,
   parameter int DEPTH    = 32,
   parameter int NREAD    = 3,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input logic               clk,
   input logic               rst_n,
   param_reg_file_sb_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   logic [XLEN-1:0]       mem [DEPTH];
   logic [DEPTH-1:0]      busy;
   logic [DEPTH-1:0]      busy_nxt;
   logic [AW:0]           cnt_q;
   logic [AW:0]           cnt_nxt;
   logic                  wr_ok;
   logic                  grant;
   logic [NREAD*XLEN-1:0] rd_v;
   logic [NREAD-1:0]      rbusy_v;

   assign wr_ok = bus.we && !((ZERO_REG != 0) && (bus.wa == '0));

   // busy[0] is never set with ZERO_REG, so register 0 always grants
   assign grant = bus.rsv_en &&
                  (!busy[bus.rsv_addr] || (bus.we && (bus.wa == bus.rsv_addr)));

   always_comb begin
      busy_nxt = busy;
      if (bus.flush) begin
         busy_nxt = '0;
      end else begin
         if (wr_ok)
            busy_nxt[bus.wa] = 1'b0;
         // reservation applied after the writeback clear so it wins on a tie
         if (grant && !((ZERO_REG != 0) && (bus.rsv_addr == '0)))
            busy_nxt[bus.rsv_addr] = 1'b1;
      end
   end

   always_comb begin
      cnt_nxt = '0;
      for (int unsigned i = 0; i < DEPTH; i++)
         cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            mem[i] <= '0;
         busy  <= '0;
         cnt_q <= '0;
      end else begin
         if (wr_ok)
            mem[bus.wa] <= bus.wd;
         busy  <= busy_nxt;
         cnt_q <= cnt_nxt;
      end
   end

   always_comb begin
      rd_v    = '0;
      rbusy_v = '0;
      for (int unsigned i = 0; i < NREAD; i++) begin
         logic [AW-1:0] a;
         a = bus.ra[i*AW +: AW];
         // gated so a bypass cannot leak write data while reset is held
         if (!rst_n || ((ZERO_REG != 0) && (a == '0))) begin
            rd_v[i*XLEN +: XLEN] = '0;
            rbusy_v[i]           = 1'b0;
         end else if ((BYPASS != 0) && bus.we && (bus.wa == a)) begin
            rd_v[i*XLEN +: XLEN] = bus.wd;
            rbusy_v[i]           = 1'b0;
         end else begin
            rd_v[i*XLEN +: XLEN] = mem[a];
            rbusy_v[i]           = busy[a];
         end
      end
   end

   assign bus.rd        = rd_v;
   assign bus.rbusy     = rbusy_v;
   assign bus.rsv_grant = grant;
   assign bus.busy_cnt  = cnt_q;
endmodule

// File: tb/tb_param_reg_file_sb.sv
// Drives an integer-style file (zero reg, bypass) and an FP-style file (neither)
// with identical stimulus and compares both against an array-based reference.
module tb_param_reg_file_sb;
   localparam int XLEN = 32, DEPTH = 32, NREAD = 3, AW = 5;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NREAD*AW-1:0] ra;
   logic                we, rsv_en, flush;
   logic [AW-1:0]       wa, rsv_addr;
   logic [XLEN-1:0]     wd;

   param_reg_file_sb_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NREAD(NREAD)) ifa ();
   param_reg_file_sb_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NREAD(NREAD)) ifb ();

   assign ifa.ra = ra;  assign ifa.we = we;  assign ifa.wa = wa;  assign ifa.wd = wd;
   assign ifa.rsv_en = rsv_en;  assign ifa.rsv_addr = rsv_addr;  assign ifa.flush = flush;
   assign ifb.ra = ra;  assign ifb.we = we;  assign ifb.wa = wa;  assign ifb.wd = wd;
   assign ifb.rsv_en = rsv_en;  assign ifb.rsv_addr = rsv_addr;  assign ifb.flush = flush;

   param_reg_file_sb #(.XLEN(XLEN), .DEPTH(DEPTH), .NREAD(NREAD), .ZERO_REG(1), .BYPASS(1))
      dut_int (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
   param_reg_file_sb #(.XLEN(XLEN), .DEPTH(DEPTH), .NREAD(NREAD), .ZERO_REG(0), .BYPASS(0))
      dut_fp (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

   int checks = 0;
   int failures = 0;

   // reference state, index 0 = integer file, 1 = FP file
   int          zr  [2] = '{1, 0};
   int          byp [2] = '{1, 0};
   logic [31:0] m_mem [2][DEPTH];
   bit          m_busy[2][DEPTH];
   bit          in_rst;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int port_addr(int p);
      logic [NREAD*AW-1:0] r;
      r = ra;
      return int'(r[p*AW +: AW]);
   endfunction

   function automatic logic [31:0] exp_rd(int c, int a);
      if (in_rst) return 0;
      if (zr[c] != 0 && a == 0) return 0;
      if (byp[c] != 0 && we && int'(wa) == a) return wd;
      return m_mem[c][a];
   endfunction

   function automatic logic [31:0] exp_rbusy(int c, int a);
      if (in_rst) return 0;
      if (zr[c] != 0 && a == 0) return 0;
      if (byp[c] != 0 && we && int'(wa) == a) return 0;
      return 32'(m_busy[c][a]);
   endfunction

   function automatic bit exp_grant(int c);
      return rsv_en && (!m_busy[c][rsv_addr] || (we && wa == rsv_addr));
   endfunction

   function automatic int exp_cnt(int c);
      int n = 0;
      for (int i = 0; i < DEPTH; i++) n += int'(m_busy[c][i]);
      return n;
   endfunction

   function automatic logic [31:0] obs_rd(int c, int p);
      logic [NREAD*XLEN-1:0] v;
      v = (c == 0) ? ifa.rd : ifb.rd;
      return v[p*XLEN +: XLEN];
   endfunction

   function automatic logic [31:0] obs_rbusy(int c, int p);
      logic [NREAD-1:0] v;
      v = (c == 0) ? ifa.rbusy : ifb.rbusy;
      return 32'(v[p]);
   endfunction

   task automatic check_comb();
      for (int c = 0; c < 2; c++) begin
         for (int p = 0; p < NREAD; p++) begin
            check($sformatf("rd[%0d] dut%0d a=%0d", p, c, port_addr(p)), obs_rd(c, p), exp_rd(c, port_addr(p)));
            check($sformatf("rbusy[%0d] dut%0d", p, c), obs_rbusy(c, p), exp_rbusy(c, port_addr(p)));
         end
         if (!in_rst)
            check($sformatf("grant dut%0d", c), 32'((c == 0) ? ifa.rsv_grant : ifb.rsv_grant), 32'(exp_grant(c)));
      end
   endtask

   task automatic check_cnt();
      check("busy_cnt dut0", 32'(ifa.busy_cnt), 32'(exp_cnt(0)));
      check("busy_cnt dut1", 32'(ifb.busy_cnt), 32'(exp_cnt(1)));
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++)
         for (int i = 0; i < DEPTH; i++) begin
            m_mem[c][i]  = '0;
            m_busy[c][i] = 1'b0;
         end
   endtask

   task automatic model_edge();
      bit g[2];
      for (int c = 0; c < 2; c++) g[c] = exp_grant(c);
      for (int c = 0; c < 2; c++) begin
         if (we && !(zr[c] != 0 && wa == 0)) m_mem[c][wa] = wd;
         if (flush) begin
            for (int i = 0; i < DEPTH; i++) m_busy[c][i] = 1'b0;
         end else begin
            if (we) m_busy[c][wa] = 1'b0;
            if (g[c] && !(zr[c] != 0 && rsv_addr == 0)) m_busy[c][rsv_addr] = 1'b1;
         end
      end
   endtask

   // inputs are set at posedge+1; combinational checks then edge then registered checks
   task automatic cycle();
      #2 check_comb();
      @(posedge clk);
      model_edge();
      #1 check_cnt();
   endtask

   task automatic idle();
      we = 0; rsv_en = 0; flush = 0; wa = '0; wd = '0; rsv_addr = '0;
   endtask

   function automatic logic [NREAD*AW-1:0] pack_ra(int a0, int a1, int a2);
      return {5'(a2), 5'(a1), 5'(a0)};
   endfunction

   initial begin
      rst_n = 1'b0; in_rst = 1'b1; ra = '0;
      idle();
      model_reset();
      #2 check_comb();
      check_cnt();
      #14 rst_n = 1'b1; in_rst = 1'b0;

      // reset sweep of every address on every port
      for (int a = 0; a < DEPTH; a++) begin
         ra = pack_ra(a, (a + 11) % DEPTH, (a + 23) % DEPTH);
         #1 check_comb();
      end
      @(posedge clk); #1;

      // zero register: write dropped on int file, kept on FP file
      ra = pack_ra(0, 0, 0); we = 1; wa = 0; wd = 32'hDEADBEEF;
      cycle();
      idle();
      #2 check("zero_reg_read", obs_rd(0, 0), 32'h0);
      check("fp_reg0_read", obs_rd(1, 0), 32'hDEADBEEF);
      rsv_en = 1; rsv_addr = 0;
      #1 check("zero_reg_grant", 32'(ifa.rsv_grant), 32'h1);
      cycle();
      check("zero_reg_cnt", 32'(ifa.busy_cnt), 32'h0);

      // same-cycle bypass vs. registered read
      idle();
      ra = pack_ra(1, 2, 5); we = 1; wa = 5; wd = 32'h3F800000;
      #2 check("bypass_int", obs_rd(0, 2), 32'h3F800000);
      check("nobypass_fp_old", obs_rd(1, 2), 32'h0);
      cycle();
      idle();
      #2 check("nobypass_fp_next", obs_rd(1, 2), 32'h3F800000);
      cycle();

      // scoreboard: reserve, denied retry, writeback+reserve tie
      ra = pack_ra(7, 7, 5); rsv_en = 1; rsv_addr = 7;
      #1 check("rsv7_grant", 32'(ifa.rsv_grant), 32'h1);
      cycle();
      check("rsv7_cnt", 32'(ifa.busy_cnt), 32'h1);
      #1 check("rsv7_rbusy", obs_rbusy(0, 0), 32'h1);
      check("rsv7_regrant", 32'(ifa.rsv_grant), 32'h0);
      cycle();
      we = 1; wa = 7; wd = 32'hCAFE0007;
      #1 check("wb_rsv7_grant", 32'(ifa.rsv_grant), 32'h1);
      cycle();
      check("wb_rsv7_cnt", 32'(ifa.busy_cnt), 32'h1);
      idle();
      #1 check("wb_rsv7_data", obs_rd(0, 0), 32'hCAFE0007);
      check("wb_rsv7_busy", obs_rbusy(0, 0), 32'h1);
      cycle();

      // clear 7, reserve 3,4,9, then flush with a write to 4
      we = 1; wa = 7; wd = 32'h00000077;
      cycle();
      idle(); rsv_en = 1;
      rsv_addr = 3; cycle();
      rsv_addr = 4; cycle();
      rsv_addr = 9; cycle();
      check("three_busy_cnt", 32'(ifa.busy_cnt), 32'h3);
      ra = pack_ra(4, 3, 9);
      flush = 1; rsv_addr = 12; we = 1; wa = 4; wd = 32'h12345678;
      cycle();
      check("flush_cnt", 32'(ifa.busy_cnt), 32'h0);
      idle();
      #1 check("flush_reg4", obs_rd(0, 0), 32'h12345678);
      cycle();

      // randomized traffic, addresses narrowed to provoke collisions
      for (int n = 0; n < 400; n++) begin
         ra       = pack_ra($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 31));
         we       = 1'($urandom_range(0, 1));
         wa       = 5'($urandom_range(0, 15));
         wd       = $urandom;
         rsv_en   = 1'($urandom_range(0, 1));
         rsv_addr = 5'($urandom_range(0, 15));
         flush    = ($urandom_range(0, 24) == 0);
         cycle();
      end

      // async reset with busy registers and nonzero data
      idle(); flush = 1; cycle();
      idle(); we = 1; wa = 10; wd = 32'hA5A5A5A5; cycle();
      idle(); rsv_en = 1; rsv_addr = 10; cycle();
      rsv_addr = 11; cycle();
      check("pre_reset_cnt", 32'(ifa.busy_cnt), 32'h2);
      idle(); ra = pack_ra(10, 11, 5); we = 1; wa = 10; wd = 32'h55555555;
      #2 rst_n = 1'b0; in_rst = 1'b1; model_reset();
      #1 check_comb();
      check_cnt();
      check("async_rst_rd0", obs_rd(0, 0), 32'h0);
      @(posedge clk); #3;
      idle();
      rst_n = 1'b1; in_rst = 1'b0;
      #1 check_comb();
      check("post_reset_rd_fp", obs_rd(1, 0), 32'h0);
      @(posedge clk); #1;
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/param_reg_file_sb.md
Name: param_reg_file_sb

Overview:
- Parametrised successor of the integer 2R/1W register file, sized to serve the integer and FP (F-extension) datapaths.
- Configurable data width, depth and read-port count. NREAD=3 covers fused multiply-add operands.
- Optional hardwired zero register, optional write-to-read bypass, and an integrated scoreboard of pending-write busy bits for multi-cycle FPU ops.
- Sits between decode/issue (reads, reservations) and writeback.

Parameters:
- XLEN, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, at least 2. Localparam AW = $clog2(DEPTH).
- NREAD, 3, number of read ports, at least 1.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy (integer file); 0 = register 0 is ordinary (FP file).
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ra  in  NREAD*AW  read addresses; port i uses bits [i*AW +: AW].
- rd  out  NREAD*XLEN  read data; port i uses bits [i*XLEN +: XLEN].
- rbusy  out  NREAD  per-port busy flag of the addressed register.
- we  in  1  writeback enable.
- wa  in  AW  writeback address.
- wd  in  XLEN  writeback data.
- rsv_en  in  1  reservation request; marks the destination as pending.
- rsv_addr  in  AW  reservation address.
- rsv_grant  out  1  reservation accepted this cycle (combinational).
- flush  in  1  synchronous clear of all busy bits.
- busy_cnt  out  AW+1  number of busy registers (registered).

Behaviour:
- Reset (rst_n low, asynchronous):
  - all DEPTH registers = 0, all busy bits = 0, busy_cnt = 0.
  - rd and rbusy are combinational, so rd = 0 and rbusy = 0 while reset is held.
- Read ports are combinational, zero latency, and independent of each other.
  - Register 0 with ZERO_REG=1: rd = 0, rbusy = 0.
  - BYPASS=1 and we=1 and wa==ra[i] (and not zero register 0): rd[i] = wd, rbusy[i] = 0.
  - BYPASS=0: rd[i] = stored value; rbusy[i] = current busy bit. Both update the cycle after the edge.
- Write: at posedge, if we=1 then reg[wa] <= wd and busy[wa] <= 0.
  - Writes to register 0 are dropped when ZERO_REG=1.
  - Writeback to a non-busy register is legal and leaves busy at 0.
- Reservation grant (combinational):
  - rsv_grant = rsv_en && (!busy[rsv_addr] || (we && wa==rsv_addr)).
  - ZERO_REG=1 and rsv_addr==0: granted, but no busy bit is set.
  - Granted reservation sets busy[rsv_addr] <= 1 at posedge.
  - Denied request (busy, no same-cycle writeback): no state change. Issue stalls and retries.
- Simultaneous writeback and grant to the same address: data is written and the busy bit ends at 1 (the new reservation wins).
- flush=1 at posedge:
  - all busy bits <= 0; any reservation that cycle is discarded.
  - a same-cycle write still updates data.
  - rsv_grant still reflects the combinational rule, but has no effect.
- busy_cnt:
  - registered popcount of the next-state busy vector; equals the number of set busy bits after each edge.
  - range 0..DEPTH (or DEPTH-1 when ZERO_REG=1).
- Register array has no per-entry reset cost constraint; it must reset to zero because the FP file relies on a defined +0.0 initial state.
- Reset asserted mid-operation discards pending reservations immediately.
- No X propagation from out-of-range addresses: DEPTH is a power of two, so none exist.

Test Plan:
- Reset, then read all addresses on all ports -> rd = 0, rbusy = 0, busy_cnt = 0.
- ZERO_REG=1:
  - write wa=0, wd=0xDEADBEEF, then read 0 -> 0.
  - rsv_en at addr 0 -> rsv_grant = 1, busy_cnt stays 0.
- Bypass:
  - BYPASS=1: we=1, wa=5, wd=0x3F800000, ra port2=5 in the same cycle -> rd port2 = 0x3F800000 that cycle.
  - BYPASS=0: same stimulus -> old value that cycle, 0x3F800000 the next cycle.
- Scoreboard sequence:
  - reserve 7 -> grant = 1; next cycle rbusy = 1 on the port reading 7, busy_cnt = 1.
  - re-reserve 7 -> grant = 0.
  - writeback 7 together with reserve 7 -> grant = 1, data written, busy stays 1, busy_cnt = 1.
- Reserve 3, 4 and 9 on consecutive cycles (busy_cnt = 3), then flush=1 with we=1, wa=4, wd=0x12345678 -> busy_cnt = 0, reg4 = 0x12345678.
- Assert rst_n low asynchronously mid-cycle with 2 registers busy and nonzero data -> outputs go to 0 and busy_cnt = 0 before the next clock edge.
